// File: rtl/grant_sequencer.sv
// Request/grant/ack service unit wrapped around an external lowest-index-wins arbiter.
// Define GRANT_TIMEOUT_EN to abandon grants that go unacknowledged for TIMEOUT cycles.
module grant_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] arb_in,
  input  logic [WIDTH-1:0] arb_out,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  input  logic             ack,
  output logic             err,
  output logic [7:0]       done_count,
  output logic             timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           r_state_q, r_state_d;
  logic [WIDTH-1:0] r_pending_q, r_pending_d;
  logic [WIDTH-1:0] r_grant_q, r_grant_d;
  logic             r_err_q, r_err_d;
  logic [7:0]       r_done_q, r_done_d;
  logic [WIDTH-1:0] w_clr;
  logic             w_onehot;

  assign w_onehot = (arb_out & (arb_out - WIDTH'(1))) == '0;

`ifdef GRANT_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] r_cnt_q, r_cnt_d;
  logic            r_timeout_q, r_timeout_d;
`endif

  always_comb begin
    r_state_d = r_state_q;
    r_grant_d = r_grant_q;
    r_err_d   = r_err_q;
    r_done_d  = r_done_q;
    w_clr     = '0;
`ifdef GRANT_TIMEOUT_EN
    r_cnt_d     = r_cnt_q;
    r_timeout_d = 1'b0;
`endif
    unique case (r_state_q)
      StIdle: begin
        if (arb_out != '0) begin
          if (w_onehot) begin
            r_grant_d = arb_out;
            r_state_d = StBusy;
`ifdef GRANT_TIMEOUT_EN
            r_cnt_d   = '0;
`endif
          end else begin
            r_err_d = 1'b1;
          end
        end
      end
      StBusy: begin
        // ack has priority over an expiring timeout on the same edge
        if (ack) begin
          w_clr     = r_grant_q;
          r_grant_d = '0;
          r_done_d  = r_done_q + 8'd1;
          r_state_d = StIdle;
        end
`ifdef GRANT_TIMEOUT_EN
        else if (r_cnt_q == CntW'(TIMEOUT - 1)) begin
          r_grant_d   = '0;
          r_state_d   = StIdle;
          r_timeout_d = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + CntW'(1);
        end
`endif
      end
      default: r_state_d = StIdle;
    endcase
    // A new request on the retiring bit re-arms it
    r_pending_d = (r_pending_q & ~w_clr) | req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q   <= StIdle;
      r_pending_q <= '0;
      r_grant_q   <= '0;
      r_err_q     <= 1'b0;
      r_done_q    <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_pending_q <= r_pending_d;
      r_grant_q   <= r_grant_d;
      r_err_q     <= r_err_d;
      r_done_q    <= r_done_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_q     <= '0;
      r_timeout_q <= 1'b0;
    end else begin
      r_cnt_q     <= r_cnt_d;
      r_timeout_q <= r_timeout_d;
    end
  end
  assign timeout = r_timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign arb_in      = r_pending_q;
  assign grant       = r_grant_q;
  assign grant_valid = (r_state_q == StBusy);
  assign err         = r_err_q;
  assign done_count  = r_done_q;

endmodule
